// File: rtl/apb_uart_pkg.sv
// Shared types and constants for the APB UART client arbiter and its clients.
// Holds the APB state encoding, client id type and UART register map.
package apb_uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef logic client_id_t;

    localparam int unsigned NUM_CLIENTS = 2;

    // Byte offsets of the apb_uart_top register file
    localparam logic [7:0] UART_RBR_THR = 8'h00;
    localparam logic [7:0] UART_IER     = 8'h04;
    localparam logic [7:0] UART_IIR_FCR = 8'h08;
    localparam logic [7:0] UART_LCR     = 8'h0C;
    localparam logic [7:0] UART_MCR     = 8'h10;
    localparam logic [7:0] UART_LSR     = 8'h14;
    localparam logic [7:0] UART_MSR     = 8'h18;
    localparam logic [7:0] UART_SCR     = 8'h1C;

    function automatic client_id_t other_client(input client_id_t id);
        return ~id;
    endfunction

    function automatic logic [1:0] client_onehot(input client_id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: the client named by ptr wins a tie.
// Purely combinational; the pointer register is owned by the caller.
module rr_arb2
    import apb_uart_pkg::*;
(
    input  logic [1:0] req,
    input  client_id_t ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (ptr == 1'b0) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end

endmodule

// File: rtl/apb_uart_arbiter.sv
// Two-client APB master sharing one APB UART slave: round-robin grant,
// SETUP/ACCESS sequencing, wait-state timeout and per-client response strobe.
module apb_uart_arbiter
    import apb_uart_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
)
(
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                PSELx,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    apb_state_t          state;
    apb_state_t          state_next;
    client_id_t          ptr;
    client_id_t          id_q;
    logic [1:0]          gnt;
    client_id_t          gnt_id;
    logic                accept;
    logic                timeout_hit;
    logic                complete;
    logic [CNT_W-1:0]    wait_cnt;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_arb2 u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt)
    );

    assign gnt_id    = gnt[1];
    assign accept    = (state == IDLE) && (gnt != 2'b00);
    assign req_ready = (PRESETn && (state == IDLE)) ? gnt : 2'b00;

    assign sel_write = gnt_id ? req_write[1] : req_write[0];
    assign sel_addr  = gnt_id ? req_addr[ADDR_W +: ADDR_W]  : req_addr[0 +: ADDR_W];
    assign sel_wdata = gnt_id ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];

    // The abort fires on the TIMEOUT_CYCLES-th low-ready ACCESS cycle; wait_cnt
    // holds the number of earlier low-ready cycles, hence the compare to N-1.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == ACCESS) && !PREADY &&
                         (wait_cnt == WAIT_LAST);
    assign complete    = (state == ACCESS) && (PREADY || timeout_hit);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        PSELx      = 1'b0;
        PENABLE    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = SETUP;
            end
            SETUP: begin
                PSELx      = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                PSELx   = 1'b1;
                PENABLE = 1'b1;
                if (complete) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch drives the APB address/data bus directly, so the bus
    // keeps its last values while idle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ptr    <= 1'b0;
            id_q   <= 1'b0;
            PWRITE <= 1'b0;
            PADDR  <= '0;
            PWDATA <= '0;
        end else if (accept) begin
            ptr    <= other_client(gnt_id);
            id_q   <= gnt_id;
            PWRITE <= sel_write;
            PADDR  <= sel_addr;
            PWDATA <= sel_wdata;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !PREADY) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            if (complete) begin
                rsp_valid <= client_onehot(id_q);
                rsp_rdata <= (timeout_hit || PWRITE) ? '0 : PRDATA;
                rsp_err   <= timeout_hit ? 1'b1 : PSLVERR;
            end
        end
    end

endmodule

// File: tb/tb_apb_uart_arbiter.sv
// Self-checking bench for apb_uart_arbiter: directed vector table, hand-written
// contention/reset sequences and randomized rounds against a transaction model.
module tb_apb_uart_arbiter;

    localparam int unsigned TO = 16;

    logic        PCLK;
    logic        PRESETn;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    apb_uart_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        int unsigned id;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned wait_n;
        bit          slverr;
        logic [31:0] prdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int unsigned exp_len;
    } txn_t;

    int unsigned errors = 0;
    int unsigned checks = 0;
    txn_t        exp_q[$];
    txn_t        drv[2];
    logic [1:0]  pend;
    int unsigned m_ptr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] onehot(input int unsigned id);
        return (id == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic txn_t mk(input int unsigned id, input bit write, input logic [31:0] addr,
                                input logic [31:0] wdata, input int unsigned wait_n, input bit slverr,
                                input logic [31:0] prdata, input logic [31:0] erd, input bit eerr,
                                input int unsigned elen);
        txn_t t;
        t.id = id; t.write = write; t.addr = addr; t.wdata = wdata;
        t.wait_n = wait_n; t.slverr = slverr; t.prdata = prdata;
        t.exp_rdata = erd; t.exp_err = eerr; t.exp_len = elen;
        return t;
    endfunction

    // Reference: outcome of one transaction from the slave's behaviour alone.
    function automatic txn_t model_resp(input txn_t t);
        txn_t r = t;
        if (t.wait_n >= TO) begin
            r.exp_len = TO; r.exp_err = 1'b1; r.exp_rdata = '0;
        end else begin
            r.exp_len = t.wait_n + 1; r.exp_err = t.slverr;
            r.exp_rdata = t.write ? 32'h0 : t.prdata;
        end
        return r;
    endfunction

    task automatic drive_reqs();
        req_valid = pend;
        for (int c = 0; c < 2; c++) begin
            req_write[c]          = drv[c].write;
            req_addr[c*32 +: 32]  = drv[c].addr;
            req_wdata[c*32 +: 32] = drv[c].wdata;
        end
    endtask

    // Runs the transactions in exp_q (expected grant order) to completion,
    // acting as the APB slave and checking bus and response behaviour.
    task automatic run_round();
        int unsigned n = exp_q.size();
        int unsigned started = 0;
        int unsigned done = 0;
        int unsigned acc_cnt = 0;
        int unsigned budget = 45 * n + 10;
        txn_t cur = exp_q[0];
        while (done < n && budget > 0) begin
            @(negedge PCLK);
            budget--;
            if (rsp_valid != 2'b00) begin
                check("rsp_valid", rsp_valid, onehot(exp_q[done].id));
                check("rsp_rdata", rsp_rdata, exp_q[done].exp_rdata);
                check("rsp_err", rsp_err, exp_q[done].exp_err);
                check("access_len", acc_cnt, exp_q[done].exp_len);
                check("psel_at_rsp", PSELx, 1'b0);
                done++;
            end
            if (PSELx) check("ready_busy", req_ready, 2'b00);
            if (PSELx && !PENABLE) begin
                if (started < n) begin
                    cur = exp_q[started];
                    check("setup_paddr", PADDR, cur.addr);
                    check("setup_pwrite", PWRITE, cur.write);
                    check("setup_pwdata", PWDATA, cur.wdata);
                end else begin
                    check("setup_extra", started, n);
                end
                started++;
                acc_cnt = 0;
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
            end else if (PSELx && PENABLE) begin
                acc_cnt++;
                check("access_paddr", PADDR, cur.addr);
                PREADY  = (acc_cnt > cur.wait_n);
                PSLVERR = PREADY ? cur.slverr : 1'b0;
                PRDATA  = cur.prdata;
            end else begin
                check("penable_idle", PENABLE, 1'b0);
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
                PRDATA  = $urandom;
            end
            drive_reqs();
            #1;
            pend = pend & ~(req_valid & req_ready);
        end
        check("round_done", done, n);
        pend = 2'b00;
        @(negedge PCLK);
        drive_reqs();
        check("rsp_quiet", rsp_valid, 2'b00);
        check("psel_quiet", PSELx, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    txn_t        tbl[9];
    txn_t        tt[2];
    logic [1:0]  mask;
    int unsigned sel;
    int unsigned first;
    logic [1:0]  exp_rsp;

    initial begin
        tbl[0] = mk(0, 1, 32'h1,  32'hA5,   0,  0, 32'hDEAD, 32'h0,    0, 1);
        tbl[1] = mk(1, 0, 32'h4,  32'h0,    3,  0, 32'h5A,   32'h5A,   0, 4);
        tbl[2] = mk(0, 0, 32'h8,  32'h11,   1,  1, 32'h77,   32'h77,   1, 2);
        tbl[3] = mk(1, 0, 32'hC,  32'h22,   0,  0, 32'h33,   32'h33,   0, 1);
        tbl[4] = mk(0, 0, 32'h10, 32'h0,    20, 0, 32'hFFFF, 32'h0,    1, 16);
        tbl[5] = mk(1, 1, 32'h14, 32'h1234, 0,  0, 32'h66,   32'h0,    0, 1);
        tbl[6] = mk(0, 0, 32'h18, 32'h0,    15, 0, 32'hABCD, 32'hABCD, 0, 16);
        tbl[7] = mk(1, 0, 32'h1C, 32'h0,    16, 0, 32'h99,   32'h0,    1, 16);
        tbl[8] = mk(0, 1, 32'h20, 32'h55,   2,  1, 32'h42,   32'h0,    1, 3);

        PRESETn = 1'b0; req_valid = 2'b11; req_write = '0;
        req_addr = {32'h200, 32'h100}; req_wdata = {32'hB, 32'hA};
        PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
        repeat (3) @(negedge PCLK);
        check("rst_psel", PSELx, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_pwrite", PWRITE, 1'b0);
        check("rst_paddr", PADDR, 32'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_req_ready", req_ready, 2'b00);

        // Contention from reset release: grants alternate 0,1,0,1 every 3 cycles.
        PRESETn = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) @(negedge PCLK);
            #1;
            check("cont_setup", PSELx && !PENABLE, (k % 3) == 1);
            if ((k % 3) == 1)
                check("cont_paddr", PADDR, ((k / 3) % 2) ? 32'h200 : 32'h100);
            exp_rsp = (k >= 3 && (k % 3) == 0) ? onehot(((k / 3) - 1) % 2) : 2'b00;
            check("cont_rsp", rsp_valid, exp_rsp);
            if ((k % 3) == 0) check("cont_ready", req_ready, onehot((k / 3) % 2));
        end
        req_valid = 2'b00;
        m_ptr = 0;
        pend = 2'b00;
        drv[0] = tbl[0]; drv[1] = tbl[1];

        for (int i = 0; i < 9; i++) begin
            drv[tbl[i].id] = tbl[i];
            exp_q.delete();
            exp_q.push_back(tbl[i]);
            pend = onehot(tbl[i].id);
            run_round();
            m_ptr = 1 - tbl[i].id;
        end

        for (int r = 0; r < 150; r++) begin
            mask = 2'($urandom_range(1, 3));
            for (int c = 0; c < 2; c++) begin
                tt[c].id     = c;
                tt[c].write  = 1'($urandom);
                tt[c].addr   = $urandom;
                tt[c].wdata  = $urandom;
                tt[c].slverr = ($urandom_range(0, 3) == 0);
                tt[c].prdata = $urandom;
                sel = $urandom_range(0, 99);
                if (sel < 60)      tt[c].wait_n = $urandom_range(0, 3);
                else if (sel < 85) tt[c].wait_n = $urandom_range(4, 15);
                else               tt[c].wait_n = $urandom_range(14, 20);
                tt[c] = model_resp(tt[c]);
                drv[c] = tt[c];
            end
            exp_q.delete();
            if (mask == 2'b11) begin
                first = m_ptr;
                exp_q.push_back(tt[first]);
                exp_q.push_back(tt[1 - first]);
            end else begin
                first = (mask == 2'b01) ? 0 : 1;
                exp_q.push_back(tt[first]);
                m_ptr = 1 - first;
            end
            pend = mask;
            run_round();
        end

        // Reset dropped mid-ACCESS on a client-0 read.
        drv[0] = mk(0, 0, 32'h30, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        pend = 2'b01; PREADY = 1'b0; PRDATA = 32'hCAFE;
        @(negedge PCLK);
        drive_reqs();
        #1;
        check("mid_ready", req_ready, 2'b01);
        @(negedge PCLK);
        pend = 2'b00; drive_reqs();
        check("mid_setup", {PSELx, PENABLE}, 2'b10);
        @(negedge PCLK);
        check("mid_access", {PSELx, PENABLE}, 2'b11);
        @(negedge PCLK);
        req_valid = 2'b11;
        PRESETn = 1'b0;
        #1;
        check("mid_rst_psel", PSELx, 1'b0);
        check("mid_rst_penable", PENABLE, 1'b0);
        check("mid_rst_pwrite", PWRITE, 1'b0);
        check("mid_rst_paddr", PADDR, 32'h0);
        check("mid_rst_pwdata", PWDATA, 32'h0);
        check("mid_rst_rsp", {rsp_valid, rsp_err}, 3'b000);
        check("mid_rst_rdata", rsp_rdata, 32'h0);
        check("mid_rst_ready", req_ready, 2'b00);
        @(negedge PCLK);
        PRESETn = 1'b1; req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge PCLK);
            check("post_rst_rsp", rsp_valid, 2'b00);
            check("post_rst_psel", PSELx, 1'b0);
        end
        tt[0] = model_resp(mk(0, 0, 32'h40, 32'h1, 1, 0, 32'h1111, 32'h0, 0, 0));
        tt[1] = model_resp(mk(1, 1, 32'h44, 32'h2, 0, 0, 32'h2222, 32'h0, 0, 0));
        drv[0] = tt[0]; drv[1] = tt[1];
        exp_q.delete();
        exp_q.push_back(tt[0]);
        exp_q.push_back(tt[1]);
        pend = 2'b11;
        run_round();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_uart_arbiter.md
# apb_uart_arbiter

Two-requester APB master that shares the single APB UART slave (`apb_uart_top`) between two on-chip clients, for example a CPU-side register port and a DMA/config sequencer. Each client posts one transaction at a time over a valid/ready request port. The block grants clients round-robin, runs the APB SETUP/ACCESS protocol, and returns read data and error status on a per-client response strobe. A wait-state timeout guards against a hung slave.

## Interface
- `ADDR_W`, 32: APB address width.
- `DATA_W`, 32: APB data width.
- `TIMEOUT_CYCLES`, 16: maximum ACCESS cycles with PREADY low before abort. 0 disables the timeout.

Ports:
- `PCLK`  in  1: clock. Everything is sampled on the rising edge.
- `PRESETn`  in  1: reset. Asynchronous assertion, active-low.
- `req_valid`  in  2: per-client request valid. Bit i belongs to client i.
- `req_write`  in  2: per-client direction. 1 = write.
- `req_addr`  in  2*ADDR_W: per-client address. Client i occupies slice [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  2*DATA_W: per-client write data, sliced the same way.
- `req_ready`  out  2: accept. A request transfers on `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  2: one-cycle completion strobe, per client.
- `rsp_rdata`  out  DATA_W: read data. Valid when any `rsp_valid` bit is high.
- `rsp_err`  out  1: error flag (PSLVERR or timeout). Valid with `rsp_valid`.
- `PSELx`, `PENABLE`, `PWRITE`  out  1 each: APB control.
- `PADDR`  out  ADDR_W, `PWDATA`  out  DATA_W: APB address and write data.
- `PRDATA`  in  DATA_W, `PREADY`  in  1, `PSLVERR`  in  1: APB slave response.

## Operation
- States are IDLE, SETUP and ACCESS.
- **IDLE**
  - The round-robin picker chooses among the asserted `req_valid` bits, starting from the priority pointer.
  - `req_ready` is combinational and is high only for the chosen client, only in IDLE.
  - On transfer, latch write/addr/wdata, record the granted id, move the pointer to the other client, and go to SETUP.
- **SETUP**
  - PSELx=1, PENABLE=0. PADDR, PWRITE and PWDATA come from the latched request.
  - Always advances to ACCESS after one cycle.
- **ACCESS**
  - PSELx=1, PENABLE=1. PADDR, PWRITE and PWDATA are held stable.
  - On PREADY=1: capture PRDATA for reads (0 for writes), capture PSLVERR, and go to IDLE.
  - Wait counter behaviour:
    - It increments on each ACCESS cycle with PREADY=0.
    - If PREADY is still low on the TIMEOUT_CYCLES-th ACCESS cycle, abort: rdata=0, err=1, go to IDLE.
- **Response**
  - `rsp_valid[id]` is registered and high for exactly the first cycle back in IDLE.
  - `rsp_rdata` and `rsp_err` hold until the next completion.
  - There is no response backpressure.
- **Pointer**
  - Reset value is client 0.
  - After a grant to i, client 1-i has priority.
  - With only one client requesting, it is granted every time.
- Outside SETUP/ACCESS, PSELx=0 and PENABLE=0. PADDR, PWDATA and PWRITE keep their last values.

## Timing
- Reset values:
  - PSELx, PENABLE, PWRITE, PADDR and PWDATA are 0.
  - `rsp_valid` is 0, `rsp_rdata` is 0, `rsp_err` is 0.
  - `req_ready` is 0 while PRESETn is low.
  - State is IDLE, pointer is 0, wait counter is 0.
- Minimum transfer, with PREADY high in the first ACCESS cycle:
  - Edge 0: accept.
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS.
  - Cycle 3: IDLE with `rsp_valid` high. A new request may be accepted in this same cycle.
  - Back-to-back throughput is therefore one transfer per 3 cycles.
- Each PREADY-low cycle adds one cycle to ACCESS.
- Simultaneous requests in IDLE: the pointer decides. The loser stays pending and is granted next.
- Reset mid-transfer: all outputs clear immediately (asynchronous). No response is issued for the aborted transaction.
- The wait-counter width is $clog2(TIMEOUT_CYCLES+1). The counter clears on every entry to SETUP.

## Structure
- Shared package `apb_uart_pkg` holds:
  - the state enum (IDLE/SETUP/ACCESS);
  - the `client_id_t` typedef;
  - the UART register offset constants used by the clients.
- Sub-module `rr_arb2`: a two-way round-robin picker (req[1:0], ptr → gnt[1:0]). It is combinational, and the pointer register lives in the parent.
- The parent contains the FSM, request latch, wait counter and response registers.

## Test plan
- **Single write:** client 0 writes addr 0x1, data 0xA5, PREADY tied 1 → PSELx high 2 cycles, PENABLE high 1 cycle, PADDR=0x1, PWDATA=0xA5, `rsp_valid`=2'b01 one cycle, `rsp_err`=0.
- **Contention:** both clients hold `req_valid` continuously from reset release → grants alternate 0,1,0,1. Each APB transfer is 3 cycles apart and carries the matching client's address.
- **Wait states:** client 1 reads addr 0x4, PREADY low for 3 ACCESS cycles, PRDATA=0x5A → ACCESS lasts 4 cycles, `rsp_valid`=2'b10, `rsp_rdata`=0x5A.
- **Slave error:** a read completes with PSLVERR=1 → `rsp_err`=1 with `rsp_valid`. The next clean transfer returns `rsp_err`=0.
- **Timeout:** PREADY held 0 → abort after 16 ACCESS cycles, `rsp_err`=1, `rsp_rdata`=0, PSELx low the following cycle, and a subsequent request is accepted normally.
- **Reset mid-ACCESS:** PRESETn dropped during ACCESS → all APB outputs and `rsp_*` are 0 immediately, with no `rsp_valid` after release. After release, client 0 has priority on a simultaneous request.
